// File: rtl/dual_port_ram_pkg.sv
// rtl/dual_port_ram_pkg.sv - shared widths and depth for the dual-port scratch RAM
package dual_port_ram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

endpackage

// File: rtl/dual_port_ram_if.sv
// rtl/dual_port_ram_if.sv - write/read port A, read port B bundle for the scratch RAM
interface dual_port_ram_if
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              we;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out_a;
    logic [DATA_W-1:0] data_out_b;

    // Producer/consumer side: drives writes and addresses, receives read data.
    modport master (
        output we,
        output addr_a,
        output addr_b,
        output data_in,
        input  data_out_a,
        input  data_out_b
    );

    // RAM side.
    modport slave (
        input  we,
        input  addr_a,
        input  addr_b,
        input  data_in,
        output data_out_a,
        output data_out_b
    );

endinterface

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - 8x8 RAM, port A write/read, port B read, read-first, 1-cycle latency
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    dual_port_ram_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // Storage update: reset clears every entry (a pending write is dropped), otherwise port A writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.we) begin
            mem[bus.addr_a] <= bus.data_in;
        end
    end

    // Registered reads on both ports; sampling mem before the write lands gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a <= '0;
            rd_b <= '0;
        end else begin
            rd_a <= mem[bus.addr_a];
            rd_b <= mem[bus.addr_b];
        end
    end

    assign bus.data_out_a = rd_a;
    assign bus.data_out_b = rd_b;

endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - directed self-checking bench with a behavioural RAM model
module tb_dual_port_ram;

    logic clk;
    logic rst;

    dual_port_ram_if bus ();

    dual_port_ram dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: an array plus the two values the ports must show.
    logic [7:0] model_mem [8];
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    bit         model_valid;

    // Hand-computed literal expectation for the current cycle.
    bit         lit_en;
    logic [7:0] lit_a;
    logic [7:0] lit_b;
    string      lit_name;

    int checks;
    int failures;

    // Compare process: runs just after each rising edge once the model is meaningful.
    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            checks++;
            if (bus.data_out_a !== exp_a) begin
                failures++;
                $display("FAIL model_a t=%0t actual=%h required=%h", $time, bus.data_out_a, exp_a);
            end
            checks++;
            if (bus.data_out_b !== exp_b) begin
                failures++;
                $display("FAIL model_b t=%0t actual=%h required=%h", $time, bus.data_out_b, exp_b);
            end
            if (lit_en) begin
                checks++;
                if (bus.data_out_a !== lit_a || exp_a !== lit_a) begin
                    failures++;
                    $display("FAIL %s_a t=%0t actual=%h model=%h required=%h",
                             lit_name, $time, bus.data_out_a, exp_a, lit_a);
                end
                checks++;
                if (bus.data_out_b !== lit_b || exp_b !== lit_b) begin
                    failures++;
                    $display("FAIL %s_b t=%0t actual=%h model=%h required=%h",
                             lit_name, $time, bus.data_out_b, exp_b, lit_b);
                end
            end
        end
    end

    // One clock cycle: apply inputs, advance the model at the edge, optionally pin literal outputs.
    task automatic cyc(input bit r, input bit w, input int aa, input int ab, input int d,
                       input bit chk, input int la, input int lb, input string name);
        rst         = r;
        bus.we      = w;
        bus.addr_a  = 3'(aa);
        bus.addr_b  = 3'(ab);
        bus.data_in = 8'(d);
        lit_en      = chk;
        lit_a       = 8'(la);
        lit_b       = 8'(lb);
        lit_name    = name;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
            exp_a = 8'h00;
            exp_b = 8'h00;
            model_valid = 1'b1;
        end else begin
            exp_a = model_mem[aa];
            exp_b = model_mem[ab];
            if (w) model_mem[aa] = 8'(d);
        end
        @(negedge clk);
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        bus.we      = 1'b0;
        bus.addr_a  = '0;
        bus.addr_b  = '0;
        bus.data_in = '0;
        model_valid = 1'b0;
        lit_en      = 1'b0;
        lit_a       = '0;
        lit_b       = '0;
        lit_name    = "";
        checks      = 0;
        failures    = 0;
        exp_a       = '0;
        exp_b       = '0;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
        @(negedge clk);

        // Reset held two cycles with a write attempt that must be ignored.
        for (int i = 0; i < 2; i++) cyc(1, 1, i, 7 - i, 8'hFF, 1, 0, 0, "reset");

        // Every address reads zero after release.
        for (int i = 0; i < 8; i++) cyc(0, 0, i, i, 0, 1, 0, 0, "post_reset_read");

        // Sequential write; read-first means port A still sees the cleared value.
        for (int i = 0; i < 8; i++) cyc(0, 1, i, i, i * 8 + 32, 1, 0, 0, "write_read_first");

        // Both ports read in parallel at crossed addresses.
        for (int i = 0; i < 8; i++)
            cyc(0, 0, i, 7 - i, 8'h5A, 1, i * 8 + 32, (7 - i) * 8 + 32, "parallel_read");

        // Same-address collision: both ports see the old word, new word on the next read.
        cyc(0, 1, 3, 3, 8'hAA, 1, 56, 56, "collision_old");
        cyc(0, 0, 3, 3, 8'h00, 1, 8'hAA, 8'hAA, "collision_new");

        // we=0 with toggling data_in: contents must not change.
        for (int i = 0; i < 8; i++)
            cyc(0, 0, i, 7 - i, (i % 2 == 0) ? 8'h55 : 8'hAA, 1,
                (i == 3) ? 8'hAA : i * 8 + 32,
                (7 - i == 3) ? 8'hAA : (7 - i) * 8 + 32, "hold");

        // Reset mid-operation during a write of 0x11 to address 5.
        cyc(1, 1, 5, 5, 8'h11, 1, 0, 0, "reset_mid");
        for (int i = 0; i < 8; i++) cyc(0, 0, i, 7 - i, 0, 1, 0, 0, "after_reset_mid");

        // A final write/read to confirm the RAM still works after the mid reset.
        cyc(0, 1, 6, 2, 8'hC3, 1, 0, 0, "rewrite");
        cyc(0, 0, 2, 6, 8'h00, 1, 0, 8'hC3, "reread");

        lit_en = 1'b0;
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
